// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcode values, FSM states
// and the hex-digit to active-low 7-segment encoder.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Segment order is gfedcba with seg[0]=a; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_scan.sv
// Time-multiplexed hex display driver: walks one digit at a time across
// the value, holding each digit enabled for REFRESH_DIV clock cycles.
module hex7seg_scan
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int REFRESH_DIV  = 1000,
  parameter int RESULT_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   value,
  output logic [RESULT_WIDTH-1:0] seg,
  output logic [DATA_WIDTH/4-1:0] dig_en
);

  localparam int NUM_DIGITS = DATA_WIDTH / 4;
  localparam int CNT_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [RESULT_WIDTH-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic [3:0]              nibble;

  // Segments are computed from the next index so seg and dig_en switch together.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nibble   = value[idx_d*4 +: 4];
    seg_d    = RESULT_WIDTH'(hex_to_seg(nibble));
    dig_en_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= RESULT_WIDTH'(7'b1000000);
      dig_en_q <= ~NUM_DIGITS'(1);
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule

// File: rtl/alu_hex7seg_scan.sv
// Handshaked 8-op ALU (IDLE -> EXEC -> DONE) whose result register is
// continuously scanned onto a multiplexed hex 7-segment display.
module alu_hex7seg_scan
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int RESULT_WIDTH = 7,
  parameter int REFRESH_DIV  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   opa,
  input  logic [DATA_WIDTH-1:0]   opb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    carry,
  output logic                    zero,
  output logic [RESULT_WIDTH-1:0] seg,
  output logic [DATA_WIDTH/4-1:0] dig_en
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;

  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;

  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res   = opa_q - opb_q;
        alu_carry = (opa_q < opb_q);
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_XNOR: alu_res = ~(opa_q ^ opb_q);
      OP_SHL:  alu_res = opa_q << opb_q[SH_W-1:0];
      default: alu_res = opa_q >> opb_q[SH_W-1:0];
    endcase
  end

  // Handshake outputs are registered alongside the state so they never glitch.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = opcode;
          opa_d      = opa;
          opb_d      = opb;
          in_ready_d = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d    = alu_res;
        carry_d     = alu_carry;
        zero_d      = (alu_res == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

  hex7seg_scan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .REFRESH_DIV (REFRESH_DIV),
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .value (result_q),
    .seg   (seg),
    .dig_en(dig_en)
  );

endmodule

// File: tb/tb_alu_hex7seg_scan.sv
// Self-checking bench for alu_hex7seg_scan: directed ALU/handshake/display
// steps plus an exhaustive 4-bit operand sweep, scored through a queue.
module tb_alu_hex7seg_scan;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic [7:0] opa;
  logic [7:0] opb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic [6:0] seg;
  logic [1:0] dig_en;

  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  int   driveCycle = 0;
  exp_t sbQueue[$];
  logic [6:0] segTable [16];

  alu_hex7seg_scan #(
    .DATA_WIDTH  (8),
    .OPCODE_WIDTH(3),
    .RESULT_WIDTH(7),
    .REFRESH_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .opa      (opa),
    .opb      (opb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .seg      (seg),
    .dig_en   (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference model built from widened integer arithmetic.
  function automatic exp_t refModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia, ib, sh, t;
    ia  = int'(a);
    ib  = int'(b);
    sh  = ib % 8;
    e.c = 1'b0;
    case (op)
      3'd0: begin t = ia + ib; e.res = 8'(t % 256); e.c = (t > 255); end
      3'd1: begin t = ia - ib; e.res = 8'((t + 256) % 256); e.c = (t < 0); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~(a ^ b);
      3'd6: e.res = 8'((ia * (1 << sh)) % 256);
      default: e.res = 8'(ia / (1 << sh));
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int waitCycles = 0;
    while (in_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    opcode   = op;
    opa      = a;
    opb      = b;
    in_valid = 1'b1;
    sbQueue.push_back(refModel(op, a, b));
    driveCycle = cycleCount;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collectResult(input string tag, input bit checkLatency);
    int   waitCycles = 0;
    exp_t e;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (out_valid === 1'b1) begin
      if (checkLatency)
        checkOutput({tag, "_latency"}, cycleCount - driveCycle, 32'd2);
      checkOutput({tag, "_sb_nonempty"}, {31'd0, sbQueue.size() != 0}, 32'd1);
      if (sbQueue.size() != 0) begin
        e = sbQueue.pop_front();
        checkOutput({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
        checkOutput({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
        checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int prevDrive;
    int runLen;
    int toggles;
    logic [1:0] prevDig;

    segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 3'd0;
    opa       = 8'd0;
    opb       = 8'd0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'h00);
    checkOutput("rst_carry", {31'd0, carry}, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    checkOutput("rst_dig_en", {30'd0, dig_en}, 32'b10);

    $display("[TB] ADD overflow");
    applyStimulus(OP_ADD, 8'hF0, 8'h20);
    collectResult("add", 1'b1);
    checkOutput("add_result_const", {24'd0, result}, 32'h10);
    checkOutput("add_carry_const", {31'd0, carry}, 32'd1);

    $display("[TB] SUB borrow and back-to-back throughput");
    prevDrive = driveCycle;
    applyStimulus(OP_SUB, 8'h03, 8'h05);
    checkOutput("throughput", driveCycle - prevDrive, 32'd3);
    collectResult("sub", 1'b1);
    checkOutput("sub_result_const", {24'd0, result}, 32'hFE);

    $display("[TB] XNOR to zero");
    applyStimulus(OP_XNOR, 8'hAA, 8'h55);
    collectResult("xnor", 1'b1);
    checkOutput("xnor_zero_const", {31'd0, zero}, 32'd1);

    $display("[TB] SHL with backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_SHL, 8'h81, 8'h09);
    @(negedge clk);
    checkOutput("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      opcode   = OP_ADD;
      opa      = 8'h11;
      opb      = 8'h22;
      checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_hold_result", {24'd0, result}, 32'h02);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collectResult("bp", 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_no_ghost_op", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("bp_sb_empty", sbQueue.size(), 32'd0);

    $display("[TB] reset during EXEC");
    applyStimulus(OP_OR, 8'h5A, 8'h0F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbQueue.delete();
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_result", {24'd0, result}, 32'h00);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_stays_idle", {31'd0, out_valid}, 32'd0);

    $display("[TB] display scan of 0x3C");
    applyStimulus(OP_ADD, 8'h3C, 8'h00);
    collectResult("disp", 1'b0);
    repeat (2) @(negedge clk);
    prevDig = dig_en;
    runLen  = 0;
    toggles = 0;
    for (int i = 0; i < 40; i++) begin
      checkOutput("scan_dig_en_onehot", {31'd0, (dig_en == 2'b01) || (dig_en == 2'b10)}, 32'd1);
      checkOutput("scan_seg", {25'd0, seg}, {25'd0, (dig_en == 2'b10) ? segTable[12] : segTable[3]});
      if (dig_en != prevDig) begin
        if (toggles > 0)
          checkOutput("scan_dwell", runLen, 32'd4);
        toggles++;
        runLen  = 1;
        prevDig = dig_en;
      end else begin
        runLen++;
      end
      @(negedge clk);
    end
    checkOutput("scan_toggles", {31'd0, toggles >= 8}, 32'd1);

    $display("[TB] exhaustive 4-bit operand sweep");
    for (int op = 0; op < 8; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(3'(op), 8'(a), 8'(b));
          collectResult("sweep", 1'b0);
        end
      end
    end
    checkOutput("sweep_sb_empty", sbQueue.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
